// File: rtl/apb_perf_snap_pkg.sv
// Shared types, mode constants and register-map index helpers for the
// event-counter snapshot bank.
package apb_perf_pkg;

   typedef logic [31:0] regs_t;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

   // Shadow array layout: counters at [0..n-1], overflow word, then sequence.
   function automatic int idx_ovf(input int n);
      return n;
   endfunction

   function automatic int idx_seq(input int n);
      return n + 1;
   endfunction

endpackage

// File: rtl/apb_perf_snap_if.sv
// Control inputs and snapshot outputs of apb_perf_snap, bundled for the
// producer (master) and the counter bank (slave).
interface apb_perf_snap_if #(
   parameter int N_CNT = 4
);
   import apb_perf_pkg::*;

   logic             en_i;
   logic [N_CNT-1:0] event_i;
   logic             clear_i;
   logic             snap_req_i;
   // regs_o is stable and readable in every cycle; snap_valid_o is a one-cycle
   // qualifier (no ready) marking the first cycle a new snapshot is visible.
   logic             snap_valid_o;
   regs_t            regs_o [N_CNT+2];

   modport master (
      output en_i, event_i, clear_i, snap_req_i,
      input  snap_valid_o, regs_o
   );

   modport slave (
      input  en_i, event_i, clear_i, snap_req_i,
      output snap_valid_o, regs_o
   );

endinterface

// File: rtl/apb_perf_snap_cnt.sv
// One event counter with sticky overflow; exposes its pre-clear next value
// and next overflow flag so a snapshot can capture them in the same cycle.
module apb_perf_cnt
   import apb_perf_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter bit SATURATE = MODE_WRAP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] next,
   output logic             ovf
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      next = cnt_q;
      ovf  = ovf_q;
      if (inc) begin
         if (cnt_q == CNT_MAX) begin
            ovf  = 1'b1;
            next = (SATURATE == MODE_SAT) ? CNT_MAX : '0;
         end else begin
            next = cnt_q + 1'b1;
         end
      end
      cnt_d = clr ? '0   : next;
      ovf_d = clr ? 1'b0 : ovf;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: rtl/apb_perf_snap.sv
// Event-counter bank with an atomic, fully registered shadow array for an
// APB read-only register slave; snapshots on request or on a periodic timer.
module apb_perf_snap
   import apb_perf_pkg::*;
#(
   parameter int          N_CNT    = 4,
   parameter int          CNT_W    = 32,
   parameter bit          SATURATE = MODE_WRAP,
   parameter int unsigned PERIOD   = 0
) (
   input  logic            pclk_i,
   input  logic            preset_i,
   apb_perf_snap_if.slave  bus
);

   localparam int          N_REGS   = N_CNT + 2;
   localparam int          IDX_OVF  = idx_ovf(N_CNT);
   localparam int          IDX_SEQ  = idx_seq(N_CNT);
   localparam logic [31:0] TMR_LAST = (PERIOD == 0) ? 32'd0 : 32'(PERIOD - 1);

   if (N_CNT < 1 || N_CNT > 32) begin : g_bad_n_cnt
      $error("apb_perf_snap: N_CNT must be in 1..32");
   end
   if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
      $error("apb_perf_snap: CNT_W must be in 1..32");
   end

   logic [N_CNT-1:0] inc;
   logic [CNT_W-1:0] cnt_next [N_CNT];
   logic [N_CNT-1:0] ovf_next;

   assign inc = {N_CNT{bus.en_i}} & bus.event_i;

   for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
      apb_perf_cnt #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_cnt (
         .clk  (pclk_i),
         .rst  (preset_i),
         .inc  (inc[i]),
         .clr  (bus.clear_i),
         .next (cnt_next[i]),
         .ovf  (ovf_next[i])
      );
   end

   logic [31:0] tmr_q, tmr_d;
   logic        expire;
   logic        trig;
   regs_t       regs_q [N_REGS];
   regs_t       regs_d [N_REGS];
   logic        valid_q, valid_d;

   // A manual request also restarts the timer so auto snapshots keep their spacing.
   always_comb begin
      tmr_d  = tmr_q;
      expire = 1'b0;
      if (PERIOD != 0) begin
         expire = (tmr_q == TMR_LAST);
         tmr_d  = (expire || bus.snap_req_i) ? 32'd0 : tmr_q + 32'd1;
      end
   end

   assign trig = bus.snap_req_i | expire;

   always_comb begin
      regs_d  = regs_q;
      valid_d = trig;
      if (trig) begin
         for (int i = 0; i < N_CNT; i++) begin
            regs_d[i] = 32'(cnt_next[i]);
         end
         regs_d[IDX_OVF] = 32'(ovf_next);
         regs_d[IDX_SEQ] = regs_q[IDX_SEQ] + 32'd1;
      end
   end

   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) begin
         tmr_q   <= '0;
         regs_q  <= '{default: '0};
         valid_q <= 1'b0;
      end else begin
         tmr_q   <= tmr_d;
         regs_q  <= regs_d;
         valid_q <= valid_d;
      end
   end

   assign bus.regs_o       = regs_q;
   assign bus.snap_valid_o = valid_q;

endmodule

// File: doc/apb_perf_snap.md
# apb_perf_snap

Event-counter bank with atomic snapshot that produces the read-only register array consumed by our APB read-only register slave. It counts up to N_CNT single-cycle event strobes and periodically or on request copies all counters into a stable shadow array. Its `regs_o` output drives that slave's register input, so software reads a coherent set of counts over APB.

## Interface
- `N_CNT`, 4: number of event counters, 1..32.
- `CNT_W`, 32: live counter width, 1..32; values are zero-extended to 32 bits in `regs_o`.
- `SATURATE`, 1'b0: 1 = counters stick at max; 0 = counters wrap.
- `PERIOD`, 0: auto-snapshot interval in cycles; 0 disables the timer.
- `N_REGS`, N_CNT+2: derived localparam; not to be overridden.

- `pclk_i` in 1: clock; all state on the rising edge.
- `preset_i` in 1: asynchronous, active-high reset.
- `en_i` in 1: global count enable; when 0, events are ignored.
- `event_i` in N_CNT: per-counter event strobes; each high cycle counts 1.
- `clear_i` in 1: synchronous clear of the live counters and overflow flags.
- `snap_req_i` in 1: snapshot request, one-cycle pulse or level.
- `snap_valid_o` out 1: one-cycle pulse; the shadow array was updated on the previous edge.
- `regs_o` out N_REGS×32: shadow array.
  - `[0..N_CNT-1]`: counter snapshots.
  - `[N_CNT]`: overflow flags, bit i for counter i, upper bits 0.
  - `[N_CNT+1]`: snapshot sequence number.

## Operation
- Live counter i next value:
  - 0 if `clear_i`.
  - Otherwise +1 if `en_i & event_i[i]`.
  - Otherwise it holds.
- Overflow with `SATURATE=0`: an increment at 2^CNT_W−1 wraps to 0 and sets sticky `ovf[i]`.
- Overflow with `SATURATE=1`: the counter holds at max and `ovf[i]` is set.
- `ovf` is cleared only by `clear_i` or reset.
- Snapshot trigger: `snap_req_i=1`, or the timer expiring (`PERIOD>0`), in that cycle.
- On a trigger edge, the shadow array captures:
  - Each counter: its pre-clear next value, i.e. the current value plus this cycle's event. `clear_i` is ignored for the captured value.
  - Flags: `ovf` including an overflow that occurs in this same cycle.
  - Sequence: old sequence + 1, wrapping at 2^32−1 → 0.
- Simultaneous `clear_i` and trigger: the snapshot holds the final counts; the live counters and `ovf` go to 0.
- Sequence number is unaffected by `clear_i`.
- Timer, `PERIOD>0`: counts 0..PERIOD−1 and expires at PERIOD−1.
  - On expiry it reloads to 0.
  - Any `snap_req_i` also restarts it at 0, so an auto-snapshot never follows a manual one by fewer than PERIOD cycles.
  - The timer runs regardless of `en_i`.
- A manual and an auto trigger in the same cycle produce exactly one snapshot and increment the sequence by 1.
- `snap_req_i` held high: a snapshot is taken every cycle and `snap_valid_o` stays high.

## Timing
- Reset values: all live counters, `ovf`, timer, sequence and `regs_o` are 0; `snap_valid_o` is 0.
- Event to live count: the count is visible internally after 1 edge. It reaches `regs_o` only through a snapshot.
- Trigger at cycle t → `regs_o` updated at edge t+1, and `snap_valid_o` is high during cycle t+1.
- `regs_o` is fully registered and changes only on snapshot edges. This guarantees coherent APB reads between snapshots.
- Reset asserted mid-operation clears everything immediately, with no pending snapshot afterward.

## Structure
- Package `apb_perf_pkg`:
  - `regs_t` (`logic [31:0]`).
  - Index functions `idx_ovf(n)` and `idx_seq(n)`.
  - Saturate and wrap mode constants.
- Sub-module `apb_perf_cnt`: one CNT_W-bit counter.
  - Inputs: `inc`, `clr`.
  - Outputs: `next`, sticky `ovf`.
  - Instantiated N_CNT times by generate.
- Top level holds the timer, trigger merge, shadow registers and sequence counter.
- Elaboration assertions: N_CNT in 1..32, CNT_W in 1..32.

## Test plan
- Reset, then 10 cycles of `event_i[0]=1`, `en_i=1`, then a `snap_req_i` pulse → next cycle `regs_o[0]=10` or 11 per the same-cycle rule, `regs_o[N_CNT+1]=1`, `snap_valid_o` high for 1 cycle.
- CNT_W=4, SATURATE=0: 17 events, then snapshot → count 1, `ovf` bit 0 = 1. Repeat with SATURATE=1 → count 15, `ovf`=1.
- `clear_i` and `snap_req_i` in the same cycle with count 5 and an event → snapshot 6; live counter 0, and a snapshot 3 cycles later reads 0 plus events in between.
- PERIOD=8, idle: `snap_valid_o` pulses every 8 cycles. A manual request at timer=5 restarts the timer, so the next auto snapshot comes 8 cycles later.
- `en_i=0` with `event_i` toggling → counts stay 0 across snapshots, while the sequence still increments.
- Assert `preset_i` mid-count with `snap_req_i` high → all outputs 0 immediately. After release, `regs_o` stays 0 until the next trigger.
